bp_me_lce_cmd_arbiter: RTL and testbench

BP_ME_LCE_CMD_ARBITER -- requirements
Module: bp_me_lce_cmd_arbiter

---
 rtl/bp_me_lce_cmd_arbiter.sv | 120 ++++++++++++
 tb/tb_bp_me_lce_cmd_arbiter.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/bp_me_lce_cmd_arbiter.sv
// Round-robin arbiter that merges several LCE command sources into one
// registered output slot feeding the LCE command packet encoder.
package bp_me_lce_cmd_arbiter_pkg;

  typedef enum logic [1:0] {
    e_bp_default_cfg,
    e_bp_inv_cfg,
    e_bp_half_core_cfg
  } bp_params_e;

  // Packed bp_lce_cmd_s width for each processor configuration.
  function automatic int lce_cmd_width(bp_params_e cfg);
    case (cfg)
      e_bp_inv_cfg:       return 48;
      e_bp_half_core_cfg: return 56;
      default:            return 64;
    endcase
  endfunction

endpackage

module bp_me_lce_cmd_arbiter
  import bp_me_lce_cmd_arbiter_pkg::*;
#(
  parameter bp_params_e bp_params_p = e_bp_inv_cfg,
  parameter int num_req_p = 2,
  localparam int lce_cmd_width_lp = lce_cmd_width(bp_params_p),
  localparam int id_width_lp = (num_req_p <= 1) ? 1 : $clog2(num_req_p)
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic [num_req_p*lce_cmd_width_lp-1:0] lce_cmd_i,
  input  logic [num_req_p-1:0]                  lce_cmd_v_i,
  output logic [num_req_p-1:0]                  lce_cmd_yumi_o,
  output logic [lce_cmd_width_lp-1:0]           lce_cmd_o,
  output logic                                  lce_cmd_v_o,
  input  logic                                  lce_cmd_ready_i,
  output logic [id_width_lp-1:0]                grant_id_o
);

  logic                        v_q, v_d;
  logic [lce_cmd_width_lp-1:0] data_q, data_d;
  logic [id_width_lp-1:0]      id_q, id_d;
  logic [id_width_lp-1:0]      last_q, last_d;

  logic                        any_v;
  logic [id_width_lp-1:0]      winner;
  logic [lce_cmd_width_lp-1:0] winner_data;
  logic                        space;
  logic                        deq;
  logic                        grant;
  int                          cand;
  logic [id_width_lp-1:0]      cand_id;

  // Output valid is forced low during reset so a held command is never offered.
  assign lce_cmd_v_o = v_q & ~reset_i;
  assign lce_cmd_o   = data_q;
  assign grant_id_o  = id_q;

  assign deq   = lce_cmd_v_o & lce_cmd_ready_i;
  assign space = ~lce_cmd_v_o | lce_cmd_ready_i;
  assign grant = any_v & space & ~reset_i;

  // Round-robin search starting just after the last granted source.
  always_comb begin
    any_v       = 1'b0;
    winner      = '0;
    winner_data = '0;
    cand        = 0;
    cand_id     = '0;
    for (int i = 1; i <= num_req_p; i++) begin
      cand = int'(last_q) + i;
      if (cand >= num_req_p) cand = cand - num_req_p;
      cand_id = cand[id_width_lp-1:0];
      if (!any_v && lce_cmd_v_i[cand_id]) begin
        any_v       = 1'b1;
        winner      = cand_id;
        winner_data = lce_cmd_i[cand*lce_cmd_width_lp +: lce_cmd_width_lp];
      end
    end
  end

  // One-hot consume strobe for the winner, only when the slot can take it.
  always_comb begin
    lce_cmd_yumi_o = '0;
    if (grant) lce_cmd_yumi_o[winner] = 1'b1;
  end

  // Slot update: a grant refills (even while draining), a bare dequeue empties.
  always_comb begin
    v_d    = v_q;
    data_d = data_q;
    id_d   = id_q;
    last_d = last_q;
    if (grant) begin
      v_d    = 1'b1;
      data_d = winner_data;
      id_d   = winner;
      last_d = winner;
    end else if (deq) begin
      v_d = 1'b0;
    end
  end

  // State registers; last_q resets to the top index so source 0 wins first.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      v_q    <= 1'b0;
      data_q <= '0;
      id_q   <= '0;
      last_q <= id_width_lp'(num_req_p - 1);
    end else begin
      v_q    <= v_d;
      data_q <= data_d;
      id_q   <= id_d;
      last_q <= last_d;
    end
  end

endmodule

// File: tb/tb_bp_me_lce_cmd_arbiter.sv
// Bench for bp_me_lce_cmd_arbiter: a 2-source and a 4-source instance,
// directed scenarios plus randomized traffic against a reference model.
module tb_bp_me_lce_cmd_arbiter;
  import bp_me_lce_cmd_arbiter_pkg::*;

  localparam int W = lce_cmd_width(e_bp_inv_cfg);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset_a, reset_b;
  logic [2*W-1:0] cmd_a;
  logic [1:0]     v_a, yumi_a;
  logic [W-1:0]   out_a;
  logic           vo_a, rdy_a;
  logic           gid_a;
  logic [4*W-1:0] cmd_b;
  logic [3:0]     v_b, yumi_b;
  logic [W-1:0]   out_b;
  logic           vo_b, rdy_b;
  logic [1:0]     gid_b;

  bp_me_lce_cmd_arbiter #(.bp_params_p(e_bp_inv_cfg), .num_req_p(2)) dut_a (
    .clk_i(clk), .reset_i(reset_a), .lce_cmd_i(cmd_a), .lce_cmd_v_i(v_a),
    .lce_cmd_yumi_o(yumi_a), .lce_cmd_o(out_a), .lce_cmd_v_o(vo_a),
    .lce_cmd_ready_i(rdy_a), .grant_id_o(gid_a)
  );

  bp_me_lce_cmd_arbiter #(.bp_params_p(e_bp_inv_cfg), .num_req_p(4)) dut_b (
    .clk_i(clk), .reset_i(reset_b), .lce_cmd_i(cmd_b), .lce_cmd_v_i(v_b),
    .lce_cmd_yumi_o(yumi_b), .lce_cmd_o(out_b), .lce_cmd_v_o(vo_b),
    .lce_cmd_ready_i(rdy_b), .grant_id_o(gid_b)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: one held slot per instance, round-robin pointer, FIFO of granted payloads.
  int           m_last [2] = '{1, 3};
  bit           m_hv   [2] = '{1'b0, 1'b0};
  logic [W-1:0] m_hd   [2] = '{'0, '0};
  int           m_hid  [2] = '{0, 0};
  logic [W-1:0] sb_a[$];
  logic [W-1:0] sb_b[$];

  function automatic int rr_pick(int last, int n, logic [7:0] v);
    for (int k = 1; k <= n; k++) begin
      int s;
      s = (last + k) % n;
      if (v[s]) return s;
    end
    return -1;
  endfunction

  task automatic model_cycle(int d, int n, bit rst, logic [7:0] v, bit rdy,
                             logic [7:0] yumi, bit vo, logic [W-1:0] o, int gid,
                             logic [8*W-1:0] cmd);
    int           w;
    logic [7:0]   exp_y;
    logic [W-1:0] front;
    logic [W-1:0] payload;
    string        pfx;
    pfx   = (d == 0) ? "a_" : "b_";
    w     = rr_pick(m_last[d], n, v);
    exp_y = '0;
    if (!rst && w >= 0 && (!m_hv[d] || rdy)) exp_y[w] = 1'b1;
    chk({pfx, "yumi"}, yumi, exp_y);
    chk({pfx, "v_o"}, vo, !rst && m_hv[d]);
    chk({pfx, "grant_id"}, gid, m_hid[d]);
    chk({pfx, "cmd_o"}, o, m_hd[d]);
    if (rst) begin
      m_hv[d] = 1'b0; m_hd[d] = '0; m_hid[d] = 0; m_last[d] = n - 1;
      if (d == 0) sb_a.delete(); else sb_b.delete();
    end else begin
      if (m_hv[d] && rdy) begin
        front = '0;
        if (d == 0) begin
          chk({pfx, "sb_depth"}, sb_a.size(), 1);
          if (sb_a.size() > 0) front = sb_a.pop_front();
        end else begin
          chk({pfx, "sb_depth"}, sb_b.size(), 1);
          if (sb_b.size() > 0) front = sb_b.pop_front();
        end
        chk({pfx, "sb_emit"}, o, front);
      end
      if (exp_y != 0) begin
        payload = cmd[w*W +: W];
        if (d == 0) sb_a.push_back(payload); else sb_b.push_back(payload);
        m_hv[d] = 1'b1; m_hd[d] = payload; m_hid[d] = w; m_last[d] = w;
      end else if (m_hv[d] && rdy) begin
        m_hv[d] = 1'b0;
      end
    end
  endtask

  task automatic tick();
    #1;
    model_cycle(0, 2, reset_a, {6'b0, v_a}, rdy_a, {6'b0, yumi_a}, vo_a, out_a,
                int'(gid_a), {{(6*W){1'b0}}, cmd_a});
    model_cycle(1, 4, reset_b, {4'b0, v_b}, rdy_b, {4'b0, yumi_b}, vo_b, out_b,
                int'(gid_b), {{(4*W){1'b0}}, cmd_b});
    @(posedge clk);
    #1;
  endtask

  task automatic rand_cmds();
    for (int i = 0; i < 2; i++) cmd_a[i*W +: W] = W'({$urandom, $urandom});
    for (int i = 0; i < 4; i++) cmd_b[i*W +: W] = W'({$urandom, $urandom});
  endtask

  logic [W-1:0] p;

  initial begin
    reset_a = 1'b1; reset_b = 1'b1;
    v_a = 2'b11; v_b = 4'b1111; rdy_a = 1'b0; rdy_b = 1'b0;
    rand_cmds();
    @(posedge clk); #1;
    @(posedge clk); #1;

    // Reset holds everything quiet even with all sources requesting.
    #1;
    chk("rst_yumi_a", yumi_a, 2'b00);
    chk("rst_vo_a", vo_a, 1'b0);
    chk("rst_gid_a", gid_a, 1'b0);
    chk("rst_yumi_b", yumi_b, 4'b0000);
    tick();

    // Two sources always valid, ready high: strict alternation starting at 0.
    reset_a = 1'b0; v_a = 2'b11; rdy_a = 1'b1;
    for (int k = 0; k < 4; k++) begin
      rand_cmds();
      #1;
      chk("rr2_yumi", yumi_a, (k % 2 == 0) ? 2'b01 : 2'b10);
      tick();
      chk("rr2_gid", gid_a, k % 2);
      chk("rr2_vo", vo_a, 1'b1);
    end

    // Drain, then a stalled output holds one command and blocks further grants.
    v_a = 2'b00; rdy_a = 1'b1;
    tick();
    v_a = 2'b01; rdy_a = 1'b0;
    rand_cmds();
    p = cmd_a[0 +: W];
    #1;
    chk("stall_first_yumi", yumi_a, 2'b01);
    tick();
    for (int k = 0; k < 5; k++) begin
      rand_cmds();
      #1;
      chk("stall_yumi", yumi_a, 2'b00);
      chk("stall_vo", vo_a, 1'b1);
      chk("stall_data", out_a, p);
      chk("stall_gid", gid_a, 1'b0);
      tick();
    end
    rdy_a = 1'b1;
    #1;
    chk("unstall_yumi", yumi_a, 2'b01);
    tick();

    // Dequeue and grant in the same cycle keep the slot full with new contents.
    v_a = 2'b10; rdy_a = 1'b1;
    rand_cmds();
    p = cmd_a[W +: W];
    #1;
    chk("b2b_yumi", yumi_a, 2'b10);
    tick();
    chk("b2b_vo", vo_a, 1'b1);
    chk("b2b_gid", gid_a, 1'b1);
    chk("b2b_data", out_a, p);

    // Reset while a command is held and stalled discards it.
    v_a = 2'b01; rdy_a = 1'b0;
    tick();
    reset_a = 1'b1; v_a = 2'b11;
    #1;
    chk("midrst_yumi", yumi_a, 2'b00);
    tick();
    chk("midrst_vo", vo_a, 1'b0);
    chk("midrst_gid", gid_a, 1'b0);
    chk("midrst_yumi2", yumi_a, 2'b00);
    reset_a = 1'b0; v_a = 2'b00;
    tick();

    // Four sources: after granting 3, the search wraps to 0 then 2.
    reset_b = 1'b0; rdy_b = 1'b1; v_b = 4'b1000;
    #1;
    chk("wrap_yumi3", yumi_b, 4'b1000);
    tick();
    chk("wrap_gid3", gid_b, 2'd3);
    v_b = 4'b0101;
    #1;
    chk("wrap_yumi0", yumi_b, 4'b0001);
    tick();
    chk("wrap_gid0", gid_b, 2'd0);
    #1;
    chk("wrap_yumi2", yumi_b, 4'b0100);
    tick();
    chk("wrap_gid2", gid_b, 2'd2);

    // Random traffic on both instances with occasional resets.
    for (int c = 0; c < 500; c++) begin
      rand_cmds();
      v_a     = 2'($urandom);
      v_b     = 4'($urandom);
      rdy_a   = ($urandom_range(0, 3) != 0);
      rdy_b   = ($urandom_range(0, 2) != 0);
      reset_a = ($urandom_range(0, 99) == 0);
      reset_b = ($urandom_range(0, 99) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
